// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, four-state debounce FSM with a
// stability window of N clocks, registered level/strobe outputs and a press counter.
module btn_debounce #(
    parameter int CLK_HZ      = 125000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in,
    output logic             btn_level,
    output logic             btn_rise,
    output logic             btn_fall,
    output logic [CNT_W-1:0] press_count,
    output logic [1:0]       dbg_state
);

    localparam int N    = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int CW   = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    localparam logic [1:0] ST_IDLE_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_IDLE_HIGH = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    logic [1:0]       sync_q,  sync_d;
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             s;

    // sync_q[1] is the only copy of the button the FSM ever looks at.
    assign sync_d = {sync_q[0], btn_in};
    assign s      = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_IDLE_LOW: begin
                if (s) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!s) begin
                    state_d = ST_IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE_HIGH: begin
                if (!s) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (s) begin
                    state_d = ST_IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_rise    = rise_q;
    assign btn_fall    = fall_q;
    assign press_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: every cycle is compared against a run-length model
// (level flips after N+1 consecutive synchronised samples of the opposite level).
module tb_btn_debounce;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int CNT_W       = 8;
  localparam int N           = CLK_HZ / 1000 * DEBOUNCE_MS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic [CNT_W-1:0] press_count;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  btn_debounce #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .press_count(press_count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_pass = 0;
  int rise_seen = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // hist[0]/hist[1]: button as sampled one and two edges ago.
  logic hist0, hist1;
  logic m_level, m_rise, m_fall;
  int m_run;
  logic [CNT_W-1:0] m_count;

  task automatic model_reset();
    hist0 = 1'b0; hist1 = 1'b0;
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    m_run = 0; m_count = '0;
  endtask

  task automatic model_step();
    logic s_seen;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s_seen = hist1;
    hist1 = hist0;
    hist0 = btn_in;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s_seen != m_level) m_run++;
    else m_run = 0;
    if (m_run == N + 1) begin
      m_level = ~m_level;
      m_run = 0;
      if (m_level) begin
        m_rise = 1'b1;
        m_count = m_count + 1'b1;
        exp_q.push_back(m_count);
      end else begin
        m_fall = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic b);
    btn_in = b;
    @(posedge clk);
    model_step();
    #1;
    check("level", btn_level, m_level);
    check("rise", btn_rise, m_rise);
    check("fall", btn_fall, m_fall);
    check("count", press_count, m_count);
    if (btn_rise && btn_fall) check("rise_and_fall", 1, 0);
    if (btn_rise) begin
      rise_seen++;
      if (exp_q.size() == 0) check("rise_unexpected", 1, 0);
      else check("rise_count", press_count, exp_q.pop_front());
    end
  endtask

  task automatic hold(input logic b, input int cycles);
    for (int i = 0; i < cycles; i++) tick(b);
  endtask

  // Drives a new held level and checks the level moves exactly N+2 edges
  // after the first edge that samples it.
  task automatic measure_latency(input logic b, input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      tick(b);
      if (btn_level == b) begin
        lat = i;
        break;
      end
    end
    check(tag, lat, N + 2);
    check({tag, "_rise"}, btn_rise, b);
    check({tag, "_fall"}, btn_fall, !b);
    tick(b);
    check({tag, "_rise_clr"}, btn_rise, 0);
    check({tag, "_fall_clr"}, btn_fall, 0);
  endtask

  task automatic async_reset_pulse(input logic b);
    rst_n = 1'b0;
    #1;
    check("rst_level", btn_level, 0);
    check("rst_rise", btn_rise, 0);
    check("rst_fall", btn_fall, 0);
    check("rst_count", press_count, 0);
    check("rst_state", dbg_state, 0);
    model_reset();
    exp_q.delete();
    hold(b, 2);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CNT_W-1:0] cnt_before;
    model_reset();
    #2;
    check("por_level", btn_level, 0);
    check("por_count", press_count, 0);
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 6);

    // clean press, then hold
    measure_latency(1'b1, "press_lat");
    hold(1'b1, 5);
    check("press_count1", press_count, 1);

    // clean release
    measure_latency(1'b0, "release_lat");
    check("release_count", press_count, 1);
    hold(1'b0, 5);

    // bounce rejection on the low side
    cnt_before = press_count;
    hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 20);
    check("bounce_level", btn_level, 0);
    check("bounce_count", press_count, cnt_before);

    // high-side glitch
    measure_latency(1'b1, "press2_lat");
    hold(1'b1, 4);
    hold(1'b0, 2); hold(1'b1, 12);
    check("glitch_level", btn_level, 1);

    // reset while high
    async_reset_pulse(1'b1);
    measure_latency(1'b1, "held_rst_lat");
    check("held_rst_count", press_count, 1);
    hold(1'b0, N + 6);

    // reset mid-window (cnt=2 in WAIT_HIGH)
    async_reset_pulse(1'b0);
    hold(1'b0, 4);
    hold(1'b1, 5);
    check("midwin_level", btn_level, 0);
    async_reset_pulse(1'b1);
    measure_latency(1'b1, "midwin_lat");
    check("midwin_count", press_count, 1);
    hold(1'b0, N + 6);

    // randomized bouncing with runs around the window length
    for (int seg = 0; seg < 300; seg++)
      hold(1'($urandom_range(0, 1)), $urandom_range(1, N + 5));
    hold(1'b0, N + 6);
    check("rand_settle_level", btn_level, 0);

    // counter wrap: 256 clean presses from reset
    async_reset_pulse(1'b0);
    rise_seen = 0;
    for (int p = 1; p <= 256; p++) begin
      hold(1'b1, N + 3);
      hold(1'b0, N + 3);
      if (p == 255) check("wrap_255", press_count, 255);
      if (p == 256) check("wrap_0", press_count, 0);
    end
    check("wrap_rises", rise_seen, 256);
    check("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
